// File: rtl/answer_judge.sv
// Quiz-buzzer judge: arms on roundStart, debounces the first buzzing player's answer,
// compares it against the target sampled at round start, scores it and holds the result.
module answer_judge #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES   = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roundStart,
  input  logic       playerInputFlag,
  input  logic [1:0] firstPlayerFlag,
  input  logic [7:0] switchInput,
  input  logic [7:0] targetValue,
  output logic       armed,
  output logic       answerValid,
  output logic       answerCorrect,
  output logic [1:0] answerPlayer,
  output logic [7:0] answerValue,
  output logic [7:0] score0,
  output logic [7:0] score1,
  output logic [7:0] score2,
  output logic [7:0] score3
);

  localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int HW = ($clog2(HOLD_CYCLES + 1) > 26) ? $clog2(HOLD_CYCLES + 1) : 26;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam bit            SETTLE_NOW  = (SETTLE_CYCLES <= 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_SETTLE = 3'd2,
    S_JUDGE  = 3'd3,
    S_HOLD   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      target_q, target_d;
  logic            arm_rel_q, arm_rel_d;
  logic [1:0]      cand_sel_q, cand_sel_d;
  logic [7:0]      cand_val_q, cand_val_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            ans_correct_q, ans_correct_d;
  logic [1:0]      ans_player_q, ans_player_d;
  logic [7:0]      ans_value_q, ans_value_d;
  logic [3:0][7:0] score_q, score_d;

  logic       cand_match;
  logic       judge_ok;
  logic [7:0] cur_score;

  assign cand_match = (firstPlayerFlag == cand_sel_q) && (switchInput == cand_val_q);
  assign judge_ok   = (cand_val_q == target_q);
  assign cur_score  = score_q[cand_sel_q];

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    arm_rel_d     = arm_rel_q;
    cand_sel_d    = cand_sel_q;
    cand_val_d    = cand_val_q;
    settle_d      = settle_q;
    hold_d        = hold_q;
    ans_correct_d = ans_correct_q;
    ans_player_d  = ans_player_q;
    ans_value_d   = ans_value_q;
    score_d       = score_q;

    case (state_q)
      S_IDLE: begin
        if (roundStart) begin
          target_d  = targetValue;
          arm_rel_d = 1'b0;
          state_d   = S_ARMED;
        end
      end

      // A button already down when the round opens must be seen released first.
      S_ARMED: begin
        if (!arm_rel_q) begin
          if (!playerInputFlag) arm_rel_d = 1'b1;
        end else if (playerInputFlag) begin
          cand_sel_d = firstPlayerFlag;
          cand_val_d = switchInput;
          settle_d   = SW'(1);
          state_d    = SETTLE_NOW ? S_JUDGE : S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (!playerInputFlag) begin
          cand_sel_d = 2'd0;
          cand_val_d = 8'd0;
          settle_d   = '0;
          arm_rel_d  = 1'b1;
          state_d    = S_ARMED;
        end else if (!cand_match) begin
          cand_sel_d = firstPlayerFlag;
          cand_val_d = switchInput;
          settle_d   = SW'(1);
        end else begin
          settle_d = settle_q + SW'(1);
          if (settle_q == SETTLE_LAST) state_d = S_JUDGE;
        end
      end

      S_JUDGE: begin
        ans_player_d  = cand_sel_q;
        ans_value_d   = cand_val_q;
        ans_correct_d = judge_ok;
        if (judge_ok) begin
          if (cur_score != 8'hFF) score_d[cand_sel_q] = cur_score + 8'd1;
        end else begin
          if (cur_score != 8'h00) score_d[cand_sel_q] = cur_score - 8'd1;
        end
        settle_d = '0;
        hold_d   = '0;
        state_d  = S_HOLD;
      end

      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      target_q      <= 8'd0;
      arm_rel_q     <= 1'b0;
      cand_sel_q    <= 2'd0;
      cand_val_q    <= 8'd0;
      settle_q      <= '0;
      hold_q        <= '0;
      ans_correct_q <= 1'b0;
      ans_player_q  <= 2'd0;
      ans_value_q   <= 8'd0;
      score_q       <= '0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      arm_rel_q     <= arm_rel_d;
      cand_sel_q    <= cand_sel_d;
      cand_val_q    <= cand_val_d;
      settle_q      <= settle_d;
      hold_q        <= hold_d;
      ans_correct_q <= ans_correct_d;
      ans_player_q  <= ans_player_d;
      ans_value_q   <= ans_value_d;
      score_q       <= score_d;
    end
  end

  assign armed         = (state_q == S_ARMED);
  assign answerValid   = (state_q == S_HOLD);
  assign answerCorrect = ans_correct_q;
  assign answerPlayer  = ans_player_q;
  assign answerValue   = ans_value_q;
  assign score0        = score_q[0];
  assign score1        = score_q[1];
  assign score2        = score_q[2];
  assign score3        = score_q[3];

endmodule

// File: tb/tb_answer_judge.sv
// Directed bench for answer_judge with SETTLE_CYCLES=4, HOLD_CYCLES=8.
module tb_answer_judge;
  localparam int SETTLE = 4;
  localparam int HOLD   = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       roundStart;
  logic       playerInputFlag;
  logic [1:0] firstPlayerFlag;
  logic [7:0] switchInput;
  logic [7:0] targetValue;
  logic       armed, answerValid, answerCorrect;
  logic [1:0] answerPlayer;
  logic [7:0] answerValue, score0, score1, score2, score3;

  int tests_run    = 0;
  int tests_failed = 0;

  answer_judge #(.SETTLE_CYCLES(SETTLE), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .roundStart(roundStart),
    .playerInputFlag(playerInputFlag), .firstPlayerFlag(firstPlayerFlag),
    .switchInput(switchInput), .targetValue(targetValue),
    .armed(armed), .answerValid(answerValid), .answerCorrect(answerCorrect),
    .answerPlayer(answerPlayer), .answerValue(answerValue),
    .score0(score0), .score1(score1), .score2(score2), .score3(score3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round(input logic [7:0] t);
    roundStart = 1'b1; targetValue = t;
    tick();
    roundStart = 1'b0;
  endtask

  task automatic release_btn();
    playerInputFlag = 1'b0; firstPlayerFlag = 2'd0; switchInput = 8'd0;
    tick();
  endtask

  // Start, release, buzz SETTLE cycles plus the JUDGE cycle: ends with HOLD freshly entered.
  task automatic run_round(input logic [7:0] t, input logic [1:0] sel, input logic [7:0] sw);
    playerInputFlag = 1'b0;
    start_round(t);
    release_btn();
    playerInputFlag = 1'b1; firstPlayerFlag = sel; switchInput = sw;
    repeat (SETTLE + 1) tick();
  endtask

  task automatic finish_hold();
    playerInputFlag = 1'b0; firstPlayerFlag = 2'd0; switchInput = 8'd0;
    repeat (HOLD) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; roundStart = 1'b1; targetValue = 8'h33;
    playerInputFlag = 1'b0; firstPlayerFlag = 2'd0; switchInput = 8'd0;
    repeat (3) tick();
    tests_run++; if ({armed, answerValid, answerCorrect} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b want 000", {armed, answerValid, answerCorrect}); end
    tests_run++; if ({answerPlayer, answerValue} !== 10'd0) begin tests_failed++; $display("FAIL reset_answer: got %h want 0", {answerPlayer, answerValue}); end
    tests_run++; if ({score0, score1, score2, score3} !== 32'd0) begin tests_failed++; $display("FAIL reset_scores: got %h want 0", {score0, score1, score2, score3}); end
    reset = 1'b1; roundStart = 1'b0;
    tick();
    tests_run++; if (armed !== 1'b0) begin tests_failed++; $display("FAIL reset_dominates_start: armed got %b want 0", armed); end
  endtask

  task automatic test_correct();
    int vcnt;
    playerInputFlag = 1'b0;
    start_round(8'h5A);
    tests_run++; if (armed !== 1'b1) begin tests_failed++; $display("FAIL correct_armed: got %b want 1", armed); end
    targetValue = 8'h00;
    release_btn();
    playerInputFlag = 1'b1; firstPlayerFlag = 2'd1; switchInput = 8'h5A;
    tick();
    tests_run++; if (armed !== 1'b0) begin tests_failed++; $display("FAIL correct_settle_armed: got %b want 0", armed); end
    repeat (SETTLE - 1) tick();
    tests_run++; if (answerValid !== 1'b0) begin tests_failed++; $display("FAIL correct_judge_cycle_valid: got %b want 0", answerValid); end
    tick();
    tests_run++; if (answerValid !== 1'b1) begin tests_failed++; $display("FAIL correct_valid: got %b want 1", answerValid); end
    tests_run++; if ({answerCorrect, answerPlayer, answerValue} !== {1'b1, 2'd1, 8'h5A}) begin tests_failed++; $display("FAIL correct_answer: got %b/%0d/%h want 1/1/5a", answerCorrect, answerPlayer, answerValue); end
    tests_run++; if ({score0, score1, score2, score3} !== 32'h00010000) begin tests_failed++; $display("FAIL correct_scores: got %h want 00010000", {score0, score1, score2, score3}); end
    playerInputFlag = 1'b0;
    vcnt = 1;
    for (int i = 0; i < HOLD + 2; i++) begin
      tick();
      if (answerValid === 1'b1) vcnt++;
    end
    tests_run++; if (vcnt !== HOLD) begin tests_failed++; $display("FAIL correct_hold_len: got %0d want %0d", vcnt, HOLD); end
    tests_run++; if ({armed, answerValid, score1} !== {2'b00, 8'd1}) begin tests_failed++; $display("FAIL correct_back_idle: got %b/%b/%0d want 0/0/1", armed, answerValid, score1); end
  endtask

  task automatic test_wrong();
    run_round(8'h10, 2'd0, 8'h11);
    tests_run++; if ({answerValid, answerCorrect, answerPlayer, answerValue} !== {1'b1, 1'b0, 2'd0, 8'h11}) begin tests_failed++; $display("FAIL wrong_answer: got %b/%b/%0d/%h want 1/0/0/11", answerValid, answerCorrect, answerPlayer, answerValue); end
    tests_run++; if (score0 !== 8'd0) begin tests_failed++; $display("FAIL wrong_floor: score0 got %0d want 0", score0); end
    finish_hold();
    for (int r = 0; r < 3; r++) begin
      run_round(8'h10, 2'd0, 8'h10);
      finish_hold();
    end
    tests_run++; if (score0 !== 8'd3) begin tests_failed++; $display("FAIL wrong_build: score0 got %0d want 3", score0); end
    run_round(8'h10, 2'd0, 8'h11);
    tests_run++; if ({answerCorrect, score0} !== {1'b0, 8'd2}) begin tests_failed++; $display("FAIL wrong_decrement: got %b/%0d want 0/2", answerCorrect, score0); end
    finish_hold();
  endtask

  task automatic test_bounce();
    playerInputFlag = 1'b0;
    start_round(8'h07);
    release_btn();
    playerInputFlag = 1'b1; firstPlayerFlag = 2'd2; switchInput = 8'h03;
    repeat (2) tick();
    playerInputFlag = 1'b0;
    tick();
    tests_run++; if ({armed, answerValid} !== 2'b10) begin tests_failed++; $display("FAIL bounce_rearm: got %b want 10", {armed, answerValid}); end
    playerInputFlag = 1'b1; switchInput = 8'h03;
    tick();
    switchInput = 8'h07;
    repeat (SETTLE) tick();
    tests_run++; if (answerValid !== 1'b0) begin tests_failed++; $display("FAIL bounce_no_early: valid got %b want 0", answerValid); end
    tick();
    tests_run++; if ({answerValid, answerCorrect, answerPlayer, answerValue} !== {1'b1, 1'b1, 2'd2, 8'h07}) begin tests_failed++; $display("FAIL bounce_answer: got %b/%b/%0d/%h want 1/1/2/07", answerValid, answerCorrect, answerPlayer, answerValue); end
    repeat (HOLD + 3) tick();
    tests_run++; if ({score0, score1, score2, score3} !== 32'h02010100) begin tests_failed++; $display("FAIL bounce_single_update: got %h want 02010100", {score0, score1, score2, score3}); end
    playerInputFlag = 1'b0;
    tick();
  endtask

  task automatic test_held();
    playerInputFlag = 1'b1; firstPlayerFlag = 2'd3; switchInput = 8'h20;
    start_round(8'h20);
    repeat (10) tick();
    tests_run++; if ({armed, answerValid, score3} !== {2'b10, 8'd0}) begin tests_failed++; $display("FAIL held_no_capture: got %b/%b/%0d want 1/0/0", armed, answerValid, score3); end
    release_btn();
    playerInputFlag = 1'b1; firstPlayerFlag = 2'd3; switchInput = 8'h20;
    repeat (SETTLE + 1) tick();
    tests_run++; if ({answerValid, answerCorrect, answerPlayer, score3} !== {2'b11, 2'd3, 8'd1}) begin tests_failed++; $display("FAIL held_capture: got %b/%b/%0d/%0d want 1/1/3/1", answerValid, answerCorrect, answerPlayer, score3); end
    finish_hold();
  endtask

  task automatic test_saturation();
    for (int r = 0; r < 254; r++) begin
      run_round(8'hC3, 2'd2, 8'hC3);
      finish_hold();
    end
    tests_run++; if (score2 !== 8'd255) begin tests_failed++; $display("FAIL sat_reach: score2 got %0d want 255", score2); end
    run_round(8'hC3, 2'd2, 8'hC3);
    tests_run++; if ({answerCorrect, score2} !== {1'b1, 8'd255}) begin tests_failed++; $display("FAIL sat_hold: got %b/%0d want 1/255", answerCorrect, score2); end
    finish_hold();
  endtask

  task automatic test_reset_hold();
    run_round(8'h44, 2'd0, 8'h44);
    roundStart = 1'b1; targetValue = 8'h00;
    tick();
    roundStart = 1'b0;
    tests_run++; if (answerValid !== 1'b1) begin tests_failed++; $display("FAIL hold_ignores_start: valid got %b want 1", answerValid); end
    playerInputFlag = 1'b0;
    repeat (HOLD - 1) tick();
    tests_run++; if ({armed, answerValid, score0} !== {2'b00, 8'd3}) begin tests_failed++; $display("FAIL hold_start_dropped: got %b/%b/%0d want 0/0/3", armed, answerValid, score0); end
    run_round(8'h44, 2'd1, 8'h44);
    tests_run++; if ({answerValid, score1} !== {1'b1, 8'd2}) begin tests_failed++; $display("FAIL pre_reset_hold: got %b/%0d want 1/2", answerValid, score1); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tests_run++; if ({armed, answerValid, answerCorrect, answerPlayer, answerValue} !== 13'd0) begin tests_failed++; $display("FAIL hold_reset_outputs: got %h want 0", {armed, answerValid, answerCorrect, answerPlayer, answerValue}); end
    tests_run++; if ({score0, score1, score2, score3} !== 32'd0) begin tests_failed++; $display("FAIL hold_reset_scores: got %h want 0", {score0, score1, score2, score3}); end
    repeat (2) tick();
    tests_run++; if ({armed, answerValid} !== 2'b00) begin tests_failed++; $display("FAIL hold_reset_idle: got %b want 00", {armed, answerValid}); end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_wrong();
    test_bounce();
    test_held();
    test_saturation();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/answer_judge.md
ANSWER_JUDGE -- requirements
Module: answer_judge

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: consecutive stable cycles of buzz input required before capture.
REQ-002 Parameter HOLD_CYCLES, default 50000000: cycles the judged result is held before returning to idle.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 roundStart  input  1  single-cycle pulse arming a new round.
REQ-006 playerInputFlag  input  1  high while any player's buzz button is active.
REQ-007 firstPlayerFlag  input  2  index of buzzing player (00=p1 .. 11=p3+1=p4).
REQ-008 switchInput  input  8  buzzing player's answer switches; 0 when no buzz.
REQ-009 targetValue  input  8  correct answer for the current round; sampled at roundStart.
REQ-010 armed  output  1  high while waiting for a buzz.
REQ-011 answerValid  output  1  high while a judged result is held.
REQ-012 answerCorrect  output  1  captured answer equals sampled target; meaningful only when answerValid.
REQ-013 answerPlayer  output  2  player index of captured answer.
REQ-014 answerValue  output  8  captured switch value.
REQ-015 score0..score3  output  8 each  per-player running score.

Function
REQ-016 States: IDLE, ARMED, SETTLE, JUDGE, HOLD; encoded one-hot or binary at implementer's choice; not exported.
REQ-017 IDLE: roundStart=1 -> register targetValue, clear armRelease, go ARMED next cycle; otherwise stay.
REQ-018 ARMED: armed=1; armRelease sets once playerInputFlag observed 0 for one cycle; buzz ignored until armRelease=1 (button held across roundStart never scores).
REQ-019 ARMED with armRelease=1 and playerInputFlag=1: latch firstPlayerFlag and switchInput as candidate, settle counter=1, go SETTLE.
REQ-020 SETTLE: each cycle with playerInputFlag=1 and inputs equal to candidate increments counter; counter reaching SETTLE_CYCLES -> JUDGE.
REQ-021 SETTLE: inputs differ from candidate while flag=1 -> reload candidate, counter=1, stay SETTLE.
REQ-022 SETTLE: playerInputFlag=0 -> discard candidate, return ARMED with armRelease=1.
REQ-023 JUDGE (exactly one cycle): answerPlayer/answerValue <= candidate; answerCorrect <= (candidate value == sampled target); update score of answerPlayer; go HOLD.
REQ-024 Score rule: correct -> +1 saturating at 255; incorrect -> -1 saturating at 0; other players' scores unchanged; 8-bit unsigned.
REQ-025 HOLD: answerValid=1, outputs frozen; hold counter counts HOLD_CYCLES cycles, then answerValid=0 and go IDLE.
REQ-026 Capture latency: JUDGE entered SETTLE_CYCLES cycles after first buzz cycle in ARMED; answerValid rises 1 cycle after JUDGE.
REQ-027 roundStart in any state other than IDLE is ignored; targetValue changes outside IDLE have no effect on the current round.
REQ-028 Only one capture per round; buzzes in HOLD and IDLE are ignored.
REQ-029 Counters sized for parameter maxima (HOLD counter >= 26 bits); no wrap before terminal count.

Reset
REQ-030 reset=0 at a clock edge, in any state including mid-SETTLE or HOLD: state IDLE, armed=0, answerValid=0, answerCorrect=0, answerPlayer=0, answerValue=0, score0..3=0, counters and candidate cleared.
REQ-031 reset dominates roundStart in the same cycle.

Verification (SETTLE_CYCLES=4, HOLD_CYCLES=8)
REQ-032 roundStart, target=0x5A; release; p2 buzz (flag=1, sel=01, sw=0x5A) held 4 cycles -> answerValid=1, answerCorrect=1, answerPlayer=01, score1=1 for 8 cycles, then IDLE.
REQ-033 Wrong answer: target=0x10, p1 sw=0x11 stable -> answerCorrect=0, score0 stays 0 (floor); repeat after score0=3 -> score0=2.
REQ-034 Bounce: flag high 2 cycles, low 1, high 4 cycles with sw changing 0x03->0x07 at cycle 2 -> single capture with answerValue=0x07, exactly one score update.
REQ-035 Button held high across roundStart and never released -> no capture, armed stays 1; release then press 4 cycles -> capture.
REQ-036 Saturation: score2=255 then correct answer -> score2 remains 255.
REQ-037 reset=0 asserted during HOLD with scores nonzero -> next cycle all outputs 0, state IDLE; roundStart during HOLD without reset -> ignored.
